ones_pattern_gen_mealy: RTL

Inverse of the ones-counter datapath. Takes a population count `CountIn` and a `Start` pulse, then serially builds a `bitInput`-bit word holding exactly that many ones, MSB-first. It streams each generated bit on `SerialOut`, and presents the finished word on a tri-stated `DataOut` bus while `Done` is high. Its intended use is as the stimulus and loopback source that feeds the ones counter on the shared data bus.

---
 rtl/ones_pattern_gen_mealy_pkg.sv | 40 ++++
 rtl/ones_pattern_gen_mealy_if.sv | 38 +++
 rtl/load_down_counter.sv | 42 ++++
 rtl/shiftReg.sv | 47 ++++
 rtl/ones_pattern_gen_mealy.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/ones_pattern_gen_mealy_pkg.sv
// -----------------------------------------------------------------------------
// ones_pattern_gen_mealy_pkg
//   Shared header for the ones-counter / ones-pattern-generator pair that sit
//   on the common data bus.
//   - Default widths: BITCOUNT (population count width) and BIT_INPUT (word
//     width and number of shift cycles).
//   - Generator FSM state codes (IDLE/SHIFT/DONE). Code 2'b11 is unused.
//   - Ones-counter control-unit state codes. They are kept next to the
//     generator codes so both blocks decode the same header.
//   - sat_count(): clamps a requested count to the word width.
// -----------------------------------------------------------------------------
package ones_pattern_gen_mealy_pkg;

    // Default datapath widths.
    localparam int BITCOUNT  = 4;
    localparam int BIT_INPUT = 8;

    // Pattern generator control FSM.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    // Ones-counter control unit.
    localparam logic [1:0] OC_IDLE  = 2'b00;
    localparam logic [1:0] OC_COUNT = 2'b01;
    localparam logic [1:0] OC_DONE  = 2'b10;

    // Clamp a requested number of ones so it never exceeds the word width.
    function automatic int unsigned sat_count(input int unsigned n,
                                              input int unsigned limit);
        int unsigned r;
        if (n > limit) begin
            r = limit;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/ones_pattern_gen_mealy_if.sv
// -----------------------------------------------------------------------------
// ones_pattern_gen_mealy_if
//   Request/status bundle of the ones pattern generator.
//   Start     : request pulse. Only sampled while the generator is idle.
//   CountIn   : requested number of ones. It is latched when Start is accepted.
//   Busy      : high while a word is being built or presented.
//   SerialOut : bit being shifted in during the current cycle.
//   Done      : one-cycle strobe. The finished word is on the data bus while
//               this is high.
//   The tri-stated data bus itself is a plain port of the generator. It is
//   shared with other bus drivers, so it is not carried in this interface.
//   master: the requester side. slave: the generator side.
// -----------------------------------------------------------------------------
interface ones_pattern_gen_mealy_if #(
    parameter int BITCOUNT_W = 4
);
    logic                  Start;
    logic [BITCOUNT_W-1:0] CountIn;
    logic                  Busy;
    logic                  SerialOut;
    logic                  Done;

    modport master (
        output Start,
        output CountIn,
        input  Busy,
        input  SerialOut,
        input  Done
    );

    modport slave (
        input  Start,
        input  CountIn,
        output Busy,
        output SerialOut,
        output Done
    );
endinterface

// File: rtl/load_down_counter.sv
// -----------------------------------------------------------------------------
// load_down_counter
//   Loadable down counter that holds the number of ones still to emit.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (clears the count)
//   i_load     : synchronous load of i_load_val (takes priority over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement enable. The count never wraps below zero.
//   o_zero     : high when the count is zero
// -----------------------------------------------------------------------------
module load_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;
    logic         w_is_zero;

    assign w_is_zero = (r_count == {W{1'b0}});

    // Count register: load wins, then a guarded decrement, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !w_is_zero) begin
            r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = w_is_zero;

endmodule

// File: rtl/shiftReg.sv
// -----------------------------------------------------------------------------
// shiftReg
//   Serial-in / parallel-out shift register with a direction select.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset (clears the register)
//   i_clear      : synchronous clear (takes priority over shifting)
//   i_shift_en   : shift one position this cycle
//   i_shift_left : 1 = shift towards the MSB (new bit enters at bit 0),
//                  0 = shift towards the LSB (new bit enters at the MSB)
//   i_serial_in  : incoming bit
//   o_q          : parallel contents. They are held when neither clear nor
//                  shift is requested.
// -----------------------------------------------------------------------------
module shiftReg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_shift_en,
    input  logic         i_shift_left,
    input  logic         i_serial_in,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Shift register: clear, shift in the selected direction, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= {W{1'b0}};
        end else if (i_clear) begin
            r_q <= {W{1'b0}};
        end else if (i_shift_en) begin
            if (i_shift_left) begin
                r_q <= {r_q[W-2:0], i_serial_in};
            end else begin
                r_q <= {i_serial_in, r_q[W-1:1]};
            end
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ones_pattern_gen_mealy.sv
// -----------------------------------------------------------------------------
// ones_pattern_gen_mealy
//   Inverse of the ones counter. On an accepted Start it builds a bitInput-bit
//   word that holds min(CountIn, bitInput) ones. The word is built MSB-first:
//   a 1 is shifted in while ones remain, and a 0 after that. The ones
//   therefore end up in the top bits of the word. The word is presented on
//   the shared tri-state bus for the single DONE cycle.
//
//   Ports
//   CLK     : rising-edge clock
//   Reset   : asynchronous active-low reset. It aborts any run at once.
//   bus     : request/status interface (Start, CountIn, Busy, SerialOut, Done)
//   DataOut : generated word. Driven only while Done=1, high-Z otherwise.
//
//   SerialOut is a Mealy output. It is derived combinationally from the state
//   and the remaining-ones counter, so it shows the bit that is being
//   shifted in during the current cycle.
// -----------------------------------------------------------------------------
module ones_pattern_gen_mealy
    import ones_pattern_gen_mealy_pkg::*;
#(
    parameter int bitcount = BITCOUNT,
    parameter int bitInput = BIT_INPUT
) (
    input  logic                    CLK,
    input  logic                    Reset,
    ones_pattern_gen_mealy_if.slave bus,
    output tri   [bitInput-1:0]     DataOut
);

    localparam int POS_W = $clog2(bitInput + 1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [POS_W-1:0]    r_pos;
    logic                w_in_shift;
    logic                w_load;
    logic                w_zero;
    logic                w_bit;
    logic                w_last;
    logic                w_drive;
    logic [bitcount-1:0] w_load_val;
    logic [bitInput-1:0] w_word;

    assign w_in_shift = (r_state == SHIFT);
    assign w_load     = (r_state == IDLE) && bus.Start;
    // One bit per SHIFT cycle: a 1 while the remaining count is nonzero.
    assign w_bit      = w_in_shift && !w_zero;
    // pos counts the shift cycles already completed. At bitInput-1 this is
    // the final shift cycle.
    assign w_last     = w_in_shift && (r_pos == POS_W'(bitInput - 1));
    assign w_drive    = (r_state == DONE);
    assign w_load_val = bitcount'(sat_count(32'(bus.CountIn), 32'(bitInput)));

    // Next-state decode. The unused code 2'b11 falls back to IDLE.
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SHIFT;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shift-cycle position: cleared on acceptance, advanced in SHIFT.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_pos <= {POS_W{1'b0}};
        end else if (w_load) begin
            r_pos <= {POS_W{1'b0}};
        end else if (w_in_shift) begin
            r_pos <= r_pos + {{(POS_W-1){1'b0}}, 1'b1};
        end else begin
            r_pos <= r_pos;
        end
    end

    // Remaining ones. It is loaded with the saturated request and counts
    // down once for each 1 that is emitted.
    load_down_counter #(
        .W (bitcount)
    ) u_remaining (
        .clk        (CLK),
        .rst_n      (Reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_bit),
        .o_zero     (w_zero)
    );

    // Word under construction. It shifts left so the first bit lands in the
    // MSB, and it holds outside SHIFT.
    shiftReg #(
        .W (bitInput)
    ) u_word (
        .clk          (CLK),
        .rst_n        (Reset),
        .i_clear      (w_load),
        .i_shift_en   (w_in_shift),
        .i_shift_left (1'b1),
        .i_serial_in  (w_bit),
        .o_q          (w_word)
    );

    assign bus.Busy      = (r_state == SHIFT) || (r_state == DONE);
    assign bus.Done      = w_drive;
    assign bus.SerialOut = w_bit;

    // Per-bit tri-state drivers onto the shared bus.
    for (genvar gi = 0; gi < bitInput; gi++) begin : g_bus_drv
        bufif1 u_drv (DataOut[gi], w_word[gi], w_drive);
    end

endmodule
